megarom_spi_master: RTL and testbench

MEGAROM_SPI_MASTER -- requirements
Module: megarom_spi_master

---
 rtl/megarom_spi_master.sv | 155 +++++++++++++++
 tb/tb_megarom_spi_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/megarom_spi_master.sv
// rtl/megarom_spi_master.sv - SPI master framing 32-bit MegaROM accesses to the CPLD
module megarom_spi_master #(
   parameter int DIV = 2,
   parameter int GAP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [18:0] cmd_addr,
   input  logic        cmd_rnw,
   input  logic [7:0]  cmd_wdata,
   input  logic        cmd_release,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        bbc_enabled,
   output logic        cpld_SCK,
   output logic        cpld_MOSI,
   output logic        cpld_SS,
   input  logic        cpld_MISO
);

   localparam logic [6:0] DIV_M1 = 7'(DIV - 1);
   localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT_LOW,
      S_SHIFT_HIGH,
      S_GAP
   } state_t;

   state_t      r_state;
   logic        r_cmd_ready;
   logic        r_rsp_valid;
   logic [7:0]  r_rsp_rdata;
   logic        r_bbc_enabled;
   logic        r_sck;
   logic        r_mosi;
   logic        r_ss;
   logic [6:0]  r_div;
   logic [5:0]  r_bit;
   logic [7:0]  r_gap;
   logic [30:0] r_shift;
   logic [7:0]  r_rx;
   logic        r_rnw;
   logic        r_release;

   // Frame in transmission order: bit 0 (sent first) is the MSB of this word.
   logic [31:0] w_frame;
   assign w_frame = {cmd_addr, cmd_rnw, (cmd_rnw ? 8'h00 : cmd_wdata), 3'b000, cmd_release};

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign bbc_enabled = r_bbc_enabled;
   assign cpld_SCK    = r_sck;
   assign cpld_MOSI   = r_mosi;
   assign cpld_SS     = r_ss;

   // Frame sequencer: accept, shift 32 SCK periods, then hold SS high for the gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= 8'h00;
         r_bbc_enabled <= 1'b1;
         r_sck         <= 1'b0;
         r_mosi        <= 1'b0;
         r_ss          <= 1'b1;
         r_div         <= 7'd0;
         r_bit         <= 6'd0;
         r_gap         <= 8'd0;
         r_shift       <= 31'd0;
         r_rx          <= 8'h00;
         r_rnw         <= 1'b0;
         r_release     <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_rnw       <= cmd_rnw;
                  r_release   <= cmd_release;
                  r_shift     <= w_frame[30:0];
                  r_mosi      <= w_frame[31];
                  r_ss        <= 1'b0;
                  r_sck       <= 1'b0;
                  r_div       <= 7'd0;
                  r_bit       <= 6'd0;
                  r_state     <= S_SHIFT_LOW;
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            S_SHIFT_LOW: begin
               if (r_div == DIV_M1) begin
                  r_div   <= 7'd0;
                  r_sck   <= 1'b1;
                  r_state <= S_SHIFT_HIGH;
                  // Only the last byte of the frame carries read data back.
                  if (r_bit >= 6'd24) begin
                     r_rx <= {r_rx[6:0], cpld_MISO};
                  end
               end else begin
                  r_div <= r_div + 7'd1;
               end
            end
            S_SHIFT_HIGH: begin
               if (r_div == DIV_M1) begin
                  r_div <= 7'd0;
                  r_sck <= 1'b0;
                  if (r_bit == 6'd31) begin
                     // The last SCK fall coincides with SS rising and the response.
                     r_ss          <= 1'b1;
                     r_mosi        <= 1'b0;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_rdata   <= r_rnw ? r_rx : 8'h00;
                     r_bbc_enabled <= r_release;
                     r_gap         <= 8'd1;
                     if (GAP == 1) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                     end else begin
                        r_state <= S_GAP;
                     end
                  end else begin
                     r_bit   <= r_bit + 6'd1;
                     r_mosi  <= r_shift[30];
                     r_shift <= {r_shift[29:0], 1'b0};
                     r_state <= S_SHIFT_LOW;
                  end
               end else begin
                  r_div <= r_div + 7'd1;
               end
            end
            S_GAP: begin
               // Ready is raised so an immediate accept leaves SS high exactly GAP cycles.
               if (r_gap == GAP_M1) begin
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_gap <= r_gap + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_megarom_spi_master.sv
// tb/tb_megarom_spi_master.sv - directed self-checking bench for megarom_spi_master
module tb_megarom_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cmd_valid;
   logic [18:0] cmd_addr;
   logic        cmd_rnw;
   logic [7:0]  cmd_wdata;
   logic        cmd_release;
   logic        cpld_MISO;

   logic        ready0, rv0, bbc0, sck0, mosi0, ss0;
   logic [7:0]  rd0;
   logic        ready1, rv1, bbc1, sck1, mosi1, ss1;
   logic [7:0]  rd1;

   megarom_spi_master #(.DIV(2), .GAP(4)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready0),
      .cmd_addr(cmd_addr), .cmd_rnw(cmd_rnw), .cmd_wdata(cmd_wdata), .cmd_release(cmd_release),
      .rsp_valid(rv0), .rsp_rdata(rd0), .bbc_enabled(bbc0),
      .cpld_SCK(sck0), .cpld_MOSI(mosi0), .cpld_SS(ss0), .cpld_MISO(cpld_MISO)
   );

   megarom_spi_master #(.DIV(1), .GAP(4)) u_dut_div1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready1),
      .cmd_addr(cmd_addr), .cmd_rnw(cmd_rnw), .cmd_wdata(cmd_wdata), .cmd_release(cmd_release),
      .rsp_valid(rv1), .rsp_rdata(rd1), .bbc_enabled(bbc1),
      .cpld_SCK(sck1), .cpld_MOSI(mosi1), .cpld_SS(ss1), .cpld_MISO(cpld_MISO)
   );

   logic sel = 1'b0;
   wire       w_ready = sel ? ready1 : ready0;
   wire       w_rv    = sel ? rv1    : rv0;
   wire [7:0] w_rd    = sel ? rd1    : rd0;
   wire       w_bbc   = sel ? bbc1   : bbc0;
   wire       w_sck   = sel ? sck1   : sck0;
   wire       w_mosi  = sel ? mosi1  : mosi0;
   wire       w_ss    = sel ? ss1    : ss0;

   int checks = 0;
   int failures = 0;

   int          cyc, ss_low, rises, first_rise, rsp_cnt, last_gap, hi_run, viol;
   logic [31:0] mosi_word;
   logic [7:0]  miso_byte = 8'h00;
   logic [7:0]  last_rdata;
   logic        prev_ss = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; ss_low = 0; rises = 0; first_rise = -1; rsp_cnt = 0;
      last_gap = -1; hi_run = 0; viol = 0; mosi_word = 32'h0; last_rdata = 8'h00;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (!w_ss) begin
         ss_low++;
         if (prev_ss) last_gap = hi_run;
         hi_run = 0;
      end else begin
         hi_run++;
      end
      if (w_sck && !prev_sck) begin
         rises++;
         mosi_word = {mosi_word[30:0], w_mosi};
         if (first_rise < 0) first_rise = cyc;
      end
      if (w_sck && prev_sck && (w_mosi !== prev_mosi)) viol++;
      if (w_ss && (w_sck || w_mosi)) viol++;
      if (w_rv) begin
         rsp_cnt++;
         last_rdata = w_rd;
         if (!(w_ss && !prev_ss)) viol++;
      end
      cpld_MISO = (!w_ss && !w_sck && rises >= 24 && rises < 32) ? miso_byte[31 - rises] : 1'b0;
      prev_ss = w_ss;
      prev_sck = w_sck;
      prev_mosi = w_mosi;
   endtask

   task automatic wait_ready(input int bound);
      int n = 0;
      while (!w_ready && n < bound) begin
         step();
         n++;
      end
      chk("wait_ready", {31'd0, w_ready}, 32'd1);
   endtask

   task automatic start_cmd(input logic [18:0] a, input logic r, input logic [7:0] wd, input logic rel);
      cmd_addr = a; cmd_rnw = r; cmd_wdata = wd; cmd_release = rel;
      cmd_valid = 1'b1;
      clear_stats();
      step();
   endtask

   task automatic run_to_end(input int bound);
      int n = 0;
      while (!w_ss && n < bound) begin
         step();
         n++;
      end
      chk("frame_end_ss", {31'd0, w_ss}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 19'h0; cmd_rnw = 1'b0;
      cmd_wdata = 8'h00; cmd_release = 1'b0; cpld_MISO = 1'b0;
      clear_stats();
      repeat (3) step();
      chk("rst_ready", {31'd0, w_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, w_rv}, 32'd0);
      chk("rst_rdata", {24'd0, w_rd}, 32'h00);
      chk("rst_bbc", {31'd0, w_bbc}, 32'd1);
      chk("rst_ss", {31'd0, w_ss}, 32'd1);
      chk("rst_sck", {31'd0, w_sck}, 32'd0);
      chk("rst_mosi", {31'd0, w_mosi}, 32'd0);
      rst = 1'b0;
      step();
      chk("ready_after_rst", {31'd0, w_ready}, 32'd1);

      // Write 0x12345 <- 0xA5, release 0
      start_cmd(19'h12345, 1'b0, 8'hA5, 1'b0);
      cmd_valid = 1'b0;
      chk("wr_t1_ss", {31'd0, w_ss}, 32'd0);
      chk("wr_t1_sck", {31'd0, w_sck}, 32'd0);
      chk("wr_t1_mosi", {31'd0, w_mosi}, 32'd0);
      chk("wr_t1_ready", {31'd0, w_ready}, 32'd0);
      run_to_end(400);
      chk("wr_ss_low", ss_low, 128);
      chk("wr_rises", rises, 32);
      chk("wr_first_rise", first_rise, 3);
      chk("wr_mosi_word", mosi_word, 32'h2468AA50);
      chk("wr_rsp_cnt", rsp_cnt, 1);
      chk("wr_rdata", {24'd0, last_rdata}, 32'h00);
      chk("wr_bbc", {31'd0, w_bbc}, 32'd0);
      chk("wr_viol", viol, 0);
      chk("wr_ready_at_ss_rise", {31'd0, w_ready}, 32'd0);
      step(); step();
      chk("wr_ready_gap_m2", {31'd0, w_ready}, 32'd0);
      step();
      chk("wr_ready_gap_m1", {31'd0, w_ready}, 32'd1);

      // Read 0x7FFFF, release 1, CPLD returns 0x3C
      miso_byte = 8'h3C;
      start_cmd(19'h7FFFF, 1'b1, 8'hFF, 1'b1);
      cmd_valid = 1'b0;
      chk("rd_t1_mosi", {31'd0, w_mosi}, 32'd1);
      run_to_end(400);
      chk("rd_rsp_valid", {31'd0, w_rv}, 32'd1);
      chk("rd_rdata", {24'd0, w_rd}, 32'h3C);
      chk("rd_mosi_word", mosi_word, 32'hFFFFF001);
      chk("rd_bbc", {31'd0, w_bbc}, 32'd1);
      chk("rd_viol", viol, 0);
      repeat (5) step();
      chk("rd_rdata_hold", {24'd0, w_rd}, 32'h3C);
      chk("rd_rsp_valid_pulse", {31'd0, w_rv}, 32'd0);

      // Back-to-back with cmd_valid held high
      miso_byte = 8'h00;
      wait_ready(20);
      start_cmd(19'h00001, 1'b0, 8'h5A, 1'b0);
      begin
         int n = 0;
         while (rsp_cnt < 2 && n < 800) begin
            step();
            n++;
         end
      end
      cmd_valid = 1'b0;
      chk("b2b_rsp_cnt", rsp_cnt, 2);
      chk("b2b_gap", last_gap, 4);
      chk("b2b_ss_low", ss_low, 256);
      chk("b2b_rises", rises, 64);
      chk("b2b_mosi_word", mosi_word, 32'h000025A0);
      chk("b2b_rdata", {24'd0, w_rd}, 32'h00);
      chk("b2b_viol", viol, 0);

      // cmd_valid pulsed while busy is ignored
      wait_ready(20);
      start_cmd(19'h40000, 1'b0, 8'h00, 1'b0);
      cmd_valid = 1'b0;
      repeat (20) step();
      cmd_addr = 19'h00000; cmd_rnw = 1'b1; cmd_release = 1'b1;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      repeat (300) step();
      chk("busy_rsp_cnt", rsp_cnt, 1);
      chk("busy_rises", rises, 32);
      chk("busy_ss_low", ss_low, 128);
      chk("busy_mosi_word", mosi_word, 32'h80000000);
      chk("busy_bbc", {31'd0, w_bbc}, 32'd0);

      // Reset at the 10th SCK rise aborts the frame
      wait_ready(20);
      start_cmd(19'h00003, 1'b1, 8'h00, 1'b0);
      cmd_valid = 1'b0;
      begin
         int n = 0;
         while (rises < 10 && n < 200) begin
            step();
            n++;
         end
      end
      chk("abort_rises", rises, 10);
      rst = 1'b1;
      step();
      chk("abort_ss", {31'd0, w_ss}, 32'd1);
      chk("abort_bbc", {31'd0, w_bbc}, 32'd1);
      chk("abort_ready", {31'd0, w_ready}, 32'd0);
      rst = 1'b0;
      step();
      chk("abort_ready_after", {31'd0, w_ready}, 32'd1);
      repeat (150) step();
      chk("abort_rsp_cnt", rsp_cnt, 0);

      // DIV=1 instance
      sel = 1'b1;
      wait_ready(20);
      start_cmd(19'h55555, 1'b0, 8'h81, 1'b1);
      cmd_valid = 1'b0;
      chk("d1_t1_mosi", {31'd0, w_mosi}, 32'd1);
      run_to_end(200);
      chk("d1_ss_low", ss_low, 64);
      chk("d1_rises", rises, 32);
      chk("d1_first_rise", first_rise, 2);
      chk("d1_mosi_word", mosi_word, 32'hAAAAA811);
      chk("d1_rsp_cnt", rsp_cnt, 1);
      chk("d1_bbc", {31'd0, w_bbc}, 32'd1);
      chk("d1_viol", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
